// File: rtl/micro_sequencer.sv
// micro_sequencer: next-address stage of the micro-programmed control unit.
// Chooses the next micro-program counter from the sequencing field. Holds a
// small return stack for micro-subroutines and a RUN/HALTED state machine.
module micro_sequencer #(
  parameter int             AW          = 8,
  parameter logic [AW-1:0]  FETCH_ADDR  = '0,
  parameter logic [AW-1:0]  MAP_BASE    = AW'('h20),
  parameter int             MAP_SHIFT   = 2,
  parameter int             STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   next_sel,
  input  logic [AW-1:0]                next_addr,
  input  logic [4:0]                   opcode,
  input  logic                         jmp,
  input  logic                         stall,
  input  logic                         resume,
  output logic [AW-1:0]                upc,
  output logic                         halted,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         stack_err
);

  localparam int IW = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    SEL_INC   = 3'd0,
    SEL_MAP   = 3'd1,
    SEL_JUMP  = 3'd2,
    SEL_CJMP  = 3'd3,
    SEL_CALL  = 3'd4,
    SEL_RET   = 3'd5,
    SEL_FETCH = 3'd6,
    SEL_HALT  = 3'd7
  } sel_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e        state_q;
  logic [AW-1:0] upc_q;
  logic [IW:0]   sp_q;
  logic          err_q;
  logic          halted_q;
  logic [AW-1:0] stack_q [STACK_DEPTH];

  logic [AW-1:0] upc_inc;
  logic [AW-1:0] map_addr;
  logic [AW-1:0] pop_addr;
  logic [IW-1:0] pop_idx;
  logic          stack_full;
  logic          stack_empty;
  logic          push_en;
  sel_e          sel;

  assign sel         = sel_e'(next_sel);
  // Both sums wrap modulo 2^AW; opcode is widened before the shift so no
  // dispatch bits are lost when the shifted opcode exceeds 5 bits.
  assign upc_inc     = upc_q + AW'(1);
  assign map_addr    = MAP_BASE + (AW'(opcode) << MAP_SHIFT);
  assign stack_full  = (sp_q == (IW+1)'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  // Low bits of sp-1 address the top entry; a full stack (sp=DEPTH) wraps
  // to the last slot, which is exactly the top.
  assign pop_idx     = sp_q[IW-1:0] - IW'(1);
  assign pop_addr    = stack_q[pop_idx];
  assign push_en     = !stall && (state_q == ST_RUN) && (sel == SEL_CALL) && !stack_full;

  // Return-stack storage: written on a non-overflowing CALL, never reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[sp_q[IW-1:0]] <= upc_inc;
    end
  end

  // Sequencer FSM: micro-PC, stack pointer, sticky error and halted flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      upc_q    <= FETCH_ADDR;
      sp_q     <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        ST_RUN: begin
          case (sel)
            SEL_INC:   upc_q <= upc_inc;
            SEL_MAP:   upc_q <= map_addr;
            SEL_JUMP:  upc_q <= next_addr;
            SEL_CJMP:  upc_q <= jmp ? next_addr : upc_inc;
            SEL_CALL: begin
              upc_q <= next_addr;
              if (stack_full) begin
                err_q <= 1'b1;
              end else begin
                sp_q <= sp_q + (IW+1)'(1);
              end
            end
            SEL_RET: begin
              if (stack_empty) begin
                upc_q <= FETCH_ADDR;
                err_q <= 1'b1;
              end else begin
                upc_q <= pop_addr;
                sp_q  <= sp_q - (IW+1)'(1);
              end
            end
            SEL_FETCH: upc_q <= FETCH_ADDR;
            SEL_HALT: begin
              state_q  <= ST_HALTED;
              halted_q <= 1'b1;
            end
            default:   upc_q <= upc_q;
          endcase
        end
        ST_HALTED: begin
          if (resume) begin
            upc_q    <= upc_inc;
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign upc       = upc_q;
  assign halted    = halted_q;
  assign sp        = sp_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed testbench for micro_sequencer with hand-computed expectations.
module tb_micro_sequencer;

  localparam logic [2:0] INC = 3'd0, MAP = 3'd1, JUMP = 3'd2, CJMP = 3'd3;
  localparam logic [2:0] CALL = 3'd4, RET = 3'd5, FETCH = 3'd6, HALT = 3'd7;

  logic       clk;
  logic       rst_n;
  logic [2:0] next_sel;
  logic [7:0] next_addr;
  logic [4:0] opcode;
  logic       jmp;
  logic       stall;
  logic       resume;
  logic [7:0] upc;
  logic       halted;
  logic [2:0] sp;
  logic       stack_err;

  int checks;
  int errors;

  micro_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .next_sel  (next_sel),
    .next_addr (next_addr),
    .opcode    (opcode),
    .jmp       (jmp),
    .stall     (stall),
    .resume    (resume),
    .upc       (upc),
    .halted    (halted),
    .sp        (sp),
    .stack_err (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given sequencing field; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic [2:0] sel, input logic [7:0] addr);
    next_sel  = sel;
    next_addr = addr;
    @(posedge clk);
    #1;
    $display("txn sel=%0d addr=%02h op=%02h jmp=%0b stall=%0b resume=%0b -> upc=%02h sp=%0d halted=%0b err=%0b",
             sel, addr, opcode, jmp, stall, resume, upc, sp, halted, stack_err);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (upc !== 8'h00) begin errors++; $display("FAIL reset_upc got %02h exp 00", upc); end
    checks++; if (sp !== 3'd0) begin errors++; $display("FAIL reset_sp got %0d exp 0", sp); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b exp 0", halted); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", stack_err); end
    rst_n = 1'b1;
    cyc(CALL, 8'h37);
    checks++; if (upc !== 8'h37 || sp !== 3'd1) begin errors++; $display("FAIL pre_reset got upc=%02h sp=%0d exp 37/1", upc, sp); end
    // Asynchronous reset mid-cycle must act without waiting for an edge.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (upc !== 8'h00 || sp !== 3'd0) begin errors++; $display("FAIL async_reset got upc=%02h sp=%0d exp 00/0", upc, sp); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_inc();
    logic [7:0] exp_upc;
    exp_upc = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cyc(INC, 8'h00);
      exp_upc = exp_upc + 8'h01;
      checks++; if (upc !== exp_upc) begin errors++; $display("FAIL inc_%0d got %02h exp %02h", i, upc, exp_upc); end
    end
    cyc(JUMP, 8'hFF);
    checks++; if (upc !== 8'hFF) begin errors++; $display("FAIL jump_ff got %02h exp FF", upc); end
    cyc(INC, 8'h00);
    checks++; if (upc !== 8'h00) begin errors++; $display("FAIL inc_wrap got %02h exp 00", upc); end
    cyc(JUMP, 8'h55);
    cyc(FETCH, 8'hAA);
    checks++; if (upc !== 8'h00) begin errors++; $display("FAIL fetch got %02h exp 00", upc); end
  endtask

  task automatic test_map();
    opcode = 5'b01011;
    cyc(MAP, 8'h00);
    checks++; if (upc !== 8'h4C) begin errors++; $display("FAIL map_0b got %02h exp 4C", upc); end
    opcode = 5'b11111;
    cyc(MAP, 8'h00);
    checks++; if (upc !== 8'h9C) begin errors++; $display("FAIL map_1f got %02h exp 9C", upc); end
    opcode = 5'b00000;
    cyc(MAP, 8'h00);
    checks++; if (upc !== 8'h20) begin errors++; $display("FAIL map_00 got %02h exp 20", upc); end
  endtask

  task automatic test_cjmp();
    cyc(JUMP, 8'h10);
    jmp = 1'b1;
    cyc(CJMP, 8'h80);
    checks++; if (upc !== 8'h80) begin errors++; $display("FAIL cjmp_taken got %02h exp 80", upc); end
    jmp = 1'b0;
    cyc(JUMP, 8'h10);
    cyc(CJMP, 8'h80);
    checks++; if (upc !== 8'h11) begin errors++; $display("FAIL cjmp_not_taken got %02h exp 11", upc); end
  endtask

  task automatic test_call_ret();
    cyc(JUMP, 8'h05);
    cyc(CALL, 8'h40);
    checks++; if (upc !== 8'h40 || sp !== 3'd1) begin errors++; $display("FAIL call1 got upc=%02h sp=%0d exp 40/1", upc, sp); end
    cyc(CALL, 8'h60);
    checks++; if (upc !== 8'h60 || sp !== 3'd2) begin errors++; $display("FAIL call2 got upc=%02h sp=%0d exp 60/2", upc, sp); end
    cyc(RET, 8'hEE);
    checks++; if (upc !== 8'h41 || sp !== 3'd1) begin errors++; $display("FAIL ret1 got upc=%02h sp=%0d exp 41/1", upc, sp); end
    cyc(RET, 8'hEE);
    checks++; if (upc !== 8'h06 || sp !== 3'd0) begin errors++; $display("FAIL ret2 got upc=%02h sp=%0d exp 06/0", upc, sp); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL call_ret_err got %0b exp 0", stack_err); end
  endtask

  task automatic test_stack_errors();
    // upc=06, sp=0: pushes 07, A1, A2, A3; the fifth CALL overflows.
    cyc(CALL, 8'hA0);
    cyc(CALL, 8'hA1);
    cyc(CALL, 8'hA2);
    cyc(CALL, 8'hA3);
    checks++; if (sp !== 3'd4 || stack_err !== 1'b0) begin errors++; $display("FAIL fill got sp=%0d err=%0b exp 4/0", sp, stack_err); end
    cyc(CALL, 8'hA4);
    checks++; if (upc !== 8'hA4 || sp !== 3'd4 || stack_err !== 1'b1) begin errors++; $display("FAIL overflow got upc=%02h sp=%0d err=%0b exp A4/4/1", upc, sp, stack_err); end
    cyc(RET, 8'h00);
    checks++; if (upc !== 8'hA3 || sp !== 3'd3) begin errors++; $display("FAIL ret_after_ovf got upc=%02h sp=%0d exp A3/3", upc, sp); end
    cyc(RET, 8'h00);
    cyc(RET, 8'h00);
    cyc(RET, 8'h00);
    checks++; if (upc !== 8'h07 || sp !== 3'd0 || stack_err !== 1'b1) begin errors++; $display("FAIL drain got upc=%02h sp=%0d err=%0b exp 07/0/1", upc, sp, stack_err); end
    do_reset();
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL err_clear got %0b exp 0", stack_err); end
    cyc(JUMP, 8'h50);
    cyc(RET, 8'h00);
    checks++; if (upc !== 8'h00 || sp !== 3'd0 || stack_err !== 1'b1) begin errors++; $display("FAIL underflow got upc=%02h sp=%0d err=%0b exp 00/0/1", upc, sp, stack_err); end
    cyc(INC, 8'h00);
    checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b exp 1", stack_err); end
  endtask

  task automatic test_halt_stall();
    do_reset();
    cyc(JUMP, 8'h22);
    cyc(HALT, 8'h00);
    checks++; if (upc !== 8'h22 || halted !== 1'b1) begin errors++; $display("FAIL halt got upc=%02h halted=%0b exp 22/1", upc, halted); end
    for (int i = 0; i < 10; i++) begin
      cyc(INC, 8'h00);
      checks++; if (upc !== 8'h22 || halted !== 1'b1) begin errors++; $display("FAIL halted_hold_%0d got upc=%02h halted=%0b exp 22/1", i, upc, halted); end
    end
    resume = 1'b1;
    stall  = 1'b1;
    cyc(INC, 8'h00);
    checks++; if (upc !== 8'h22 || halted !== 1'b1) begin errors++; $display("FAIL resume_stalled got upc=%02h halted=%0b exp 22/1", upc, halted); end
    stall = 1'b0;
    cyc(INC, 8'h00);
    checks++; if (upc !== 8'h23 || halted !== 1'b0) begin errors++; $display("FAIL resume got upc=%02h halted=%0b exp 23/0", upc, halted); end
    // resume held in RUN has no effect beyond the normal INC.
    cyc(INC, 8'h00);
    checks++; if (upc !== 8'h24 || halted !== 1'b0) begin errors++; $display("FAIL resume_in_run got upc=%02h halted=%0b exp 24/0", upc, halted); end
    resume = 1'b0;
    cyc(JUMP, 8'h30);
    stall = 1'b1;
    cyc(CALL, 8'h70);
    checks++; if (upc !== 8'h30 || sp !== 3'd0) begin errors++; $display("FAIL stall_call got upc=%02h sp=%0d exp 30/0", upc, sp); end
    cyc(HALT, 8'h00);
    checks++; if (halted !== 1'b0 || upc !== 8'h30) begin errors++; $display("FAIL stall_halt got upc=%02h halted=%0b exp 30/0", upc, halted); end
    stall = 1'b0;
    cyc(CALL, 8'h70);
    checks++; if (upc !== 8'h70 || sp !== 3'd1) begin errors++; $display("FAIL call_after_stall got upc=%02h sp=%0d exp 70/1", upc, sp); end
  endtask

  task automatic test_back_to_back();
    // sp=1 with 31 on the stack; CALL then immediate RET, then pop the rest.
    cyc(CALL, 8'h90);
    cyc(RET, 8'h00);
    checks++; if (upc !== 8'h71 || sp !== 3'd1) begin errors++; $display("FAIL b2b_ret got upc=%02h sp=%0d exp 71/1", upc, sp); end
    cyc(RET, 8'h00);
    checks++; if (upc !== 8'h31 || sp !== 3'd0) begin errors++; $display("FAIL b2b_ret2 got upc=%02h sp=%0d exp 31/0", upc, sp); end
    opcode = 5'b00101;
    jmp    = 1'b1;
    cyc(MAP, 8'h00);
    cyc(CJMP, 8'hC8);
    checks++; if (upc !== 8'hC8) begin errors++; $display("FAIL map_cjmp got %02h exp C8", upc); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL b2b_err got %0b exp 0", stack_err); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    next_sel  = INC;
    next_addr = 8'h00;
    opcode    = 5'd0;
    jmp       = 1'b0;
    stall     = 1'b0;
    resume    = 1'b0;
    test_reset();
    test_inc();
    test_map();
    test_cjmp();
    test_call_ret();
    test_stack_errors();
    test_halt_stall();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
